// File: rtl/keypad_onehot_capture.sv
// keypad_onehot_capture
//   Front end for the decimal encoder. Ten raw push-buttons (digit i on bit i)
//   are synchronised through two flops, debounced, and screened for multi-key
//   presses. The accepted digit is presented as a registered, strictly
//   one-hot code on X. X therefore never reaches the encoder as zero-hot or
//   multi-hot.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   keys_raw   in  10   raw button levels, active-high, asynchronous to clk
//   X          out 10   registered one-hot code of the last accepted digit
//   key_valid  out  1   one-cycle pulse in the cycle X takes an accepted value
//   key_held   out  1   high while the accepted key is considered pressed
//   multi_key  out  1   one-cycle pulse on two or more keys while idle/debouncing
//
// Parameters
//   DB_CYCLES      consecutive identical samples needed to accept press/release (>= 2)
//   REPEAT_CYCLES  auto-repeat interval, only meaningful with AUTO_REPEAT_EN
//
// Build option
//   AUTO_REPEAT_EN  when defined, a held key re-pulses key_valid every
//                   REPEAT_CYCLES cycles. When not defined, no repeat logic is
//                   built and each press yields exactly one key_valid.
module keypad_onehot_capture #(
  parameter int DB_CYCLES     = 8,
  parameter int REPEAT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] keys_raw,
  output logic [9:0] X,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int CNT_MAX_C = (DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX_C) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  localparam logic [9:0] X_RESET = 10'b0000000001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Number of set bits in a key vector.
  function automatic logic [3:0] ones_count(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Saturating increment: a counter parks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == CNT_SAT) begin
      r = c;
    end else begin
      r = c + CNT_ONE;
    end
    return r;
  endfunction

  logic [9:0]       s1_r, s2_r;
  state_t           state_r, state_nxt_s;
  logic [9:0]       cand_r, cand_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [9:0]       x_r, x_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             held_r, held_nxt_s;
  logic             multi_r, multi_nxt_s;
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rep_r, rep_nxt_s;
`endif

  logic [3:0] pop_s;
  logic       is_zero_s, is_onehot_s, is_multi_s;

  assign pop_s       = ones_count(s2_r);
  assign is_zero_s   = (pop_s == 4'd0);
  assign is_onehot_s = (pop_s == 4'd1);
  assign is_multi_s  = (pop_s >= 4'd2);

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r <= 10'b0000000000;
      s2_r <= 10'b0000000000;
    end else begin
      s1_r <= keys_raw;
      s2_r <= s1_r;
    end
  end

  // Next-state and next-output logic for the debounce / accept FSM.
  always_comb begin
    state_nxt_s = state_r;
    cand_nxt_s  = cand_r;
    cnt_nxt_s   = cnt_r;
    x_nxt_s     = x_r;
    held_nxt_s  = held_r;
    valid_nxt_s = 1'b0;
    multi_nxt_s = 1'b0;
`ifdef AUTO_REPEAT_EN
    // The repeat counter only survives a cycle spent in PRESSED on the same key.
    rep_nxt_s   = CNT_ZERO;
`endif

    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (is_onehot_s) begin
          cand_nxt_s  = s2_r;
          cnt_nxt_s   = CNT_ONE;
          state_nxt_s = ST_DEBOUNCE;
        end else if (is_multi_s) begin
          multi_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_DEBOUNCE: begin
        if (s2_r == cand_r) begin
          if (cnt_r >= DB_LAST) begin
            x_nxt_s     = cand_r;
            valid_nxt_s = 1'b1;
            held_nxt_s  = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_PRESSED;
          end else begin
            cnt_nxt_s = sat_inc(cnt_r);
          end
        end else begin
          // Any disagreement aborts; the new sample is not used as a fresh start.
          cnt_nxt_s   = CNT_ZERO;
          multi_nxt_s = is_multi_s;
          state_nxt_s = ST_IDLE;
        end
      end

      ST_PRESSED: begin
        if (is_zero_s) begin
          cnt_nxt_s   = CNT_ONE;
          state_nxt_s = ST_RELEASE;
        end else begin
          // Roll-over is blocked: extra or different keys are ignored here.
          cnt_nxt_s = CNT_ZERO;
`ifdef AUTO_REPEAT_EN
          if (s2_r == x_r) begin
            if (rep_r >= REP_LAST) begin
              valid_nxt_s = 1'b1;
              rep_nxt_s   = CNT_ZERO;
            end else begin
              rep_nxt_s = sat_inc(rep_r);
            end
          end else begin
            rep_nxt_s = CNT_ZERO;
          end
`endif
        end
      end

      ST_RELEASE: begin
        if (is_zero_s) begin
          if (cnt_r >= DB_LAST) begin
            held_nxt_s  = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = sat_inc(cnt_r);
          end
        end else begin
          // Release glitch: the key is still down.
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_PRESSED;
        end
      end

      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cand_r  <= 10'b0000000000;
      cnt_r   <= CNT_ZERO;
      x_r     <= X_RESET;
      valid_r <= 1'b0;
      held_r  <= 1'b0;
      multi_r <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_r   <= CNT_ZERO;
`endif
    end else begin
      state_r <= state_nxt_s;
      cand_r  <= cand_nxt_s;
      cnt_r   <= cnt_nxt_s;
      x_r     <= x_nxt_s;
      valid_r <= valid_nxt_s;
      held_r  <= held_nxt_s;
      multi_r <= multi_nxt_s;
`ifdef AUTO_REPEAT_EN
      rep_r   <= rep_nxt_s;
`endif
    end
  end

  assign X         = x_r;
  assign key_valid = valid_r;
  assign key_held  = held_r;
  assign multi_key = multi_r;

endmodule

// File: tb/tb_keypad_onehot_capture.sv
// Self-checking bench for keypad_onehot_capture: directed scenarios followed by
// randomized key episodes, compared every cycle against a behavioural model.
module tb_keypad_onehot_capture;

  localparam int DB  = 8;
  localparam int REP = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [9:0] keys_raw = 10'b0000000000;
  logic [9:0] X;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  always #5 clk = ~clk;

  keypad_onehot_capture #(
    .DB_CYCLES    (DB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .keys_raw (keys_raw),
    .X        (X),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: key history for the sync delay plus press bookkeeping.
  logic [9:0] hist_q[$];
  logic [9:0] m_x      = 10'b0000000001;
  logic [9:0] m_cand   = 10'b0000000000;
  bit         m_valid  = 1'b0;
  bit         m_held   = 1'b0;
  bit         m_multi  = 1'b0;
  bit         m_down   = 1'b0;   // a key has been accepted and not yet released
  bit         m_track  = 1'b0;   // a single-key candidate is being timed
  int         m_run    = 0;      // matching samples seen for the candidate
  int         m_quiet  = 0;      // consecutive empty samples while a key is down
`ifdef AUTO_REPEAT_EN
  int         m_hold   = 0;      // cycles the accepted key has stayed down unchanged
`endif

  int valid_seen = 0;
  int multi_seen = 0;
  int lat_valid;
  int lat_fall;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_q  = '{10'b0000000000, 10'b0000000000};
    m_x     = 10'b0000000001;
    m_valid = 1'b0;
    m_held  = 1'b0;
    m_multi = 1'b0;
    m_down  = 1'b0;
    m_track = 1'b0;
    m_run   = 0;
    m_quiet = 0;
`ifdef AUTO_REPEAT_EN
    m_hold  = 0;
`endif
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [9:0] s;
    int         n;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = hist_q.pop_front();      // what the design sees: keys from two edges ago
      hist_q.push_back(keys_raw);
      n = $countones(s);
      m_valid = 1'b0;
      m_multi = 1'b0;
      if (!m_down) begin
        if (!m_track) begin
          if (n == 1) begin
            m_track = 1'b1;
            m_cand  = s;
            m_run   = 1;
          end else if (n > 1) begin
            m_multi = 1'b1;
          end
        end else if (s == m_cand) begin
          if (m_run == DB - 1) begin
            m_x     = m_cand;
            m_valid = 1'b1;
            m_held  = 1'b1;
            m_down  = 1'b1;
            m_track = 1'b0;
            m_quiet = 0;
`ifdef AUTO_REPEAT_EN
            m_hold  = 0;
`endif
          end else begin
            m_run++;
          end
        end else begin
          m_track = 1'b0;
          if (n > 1) m_multi = 1'b1;
        end
      end else begin
        if (n == 0) begin
          if (m_quiet == DB - 1) begin
            m_down  = 1'b0;
            m_held  = 1'b0;
            m_quiet = 0;
          end else begin
            m_quiet++;
          end
`ifdef AUTO_REPEAT_EN
          m_hold = 0;
`endif
        end else if (m_quiet != 0) begin
          m_quiet = 0;
`ifdef AUTO_REPEAT_EN
          m_hold  = 0;
`endif
        end else begin
`ifdef AUTO_REPEAT_EN
          if (s == m_x) begin
            m_hold++;
            if (m_hold == REP) begin
              m_valid = 1'b1;
              m_hold  = 0;
            end
          end else begin
            m_hold = 0;
          end
`endif
        end
      end
    end
  endtask

  // Run n clock cycles, comparing the DUT with the model after every edge.
  task automatic step(input int n);
    lat_valid = -1;
    lat_fall  = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_val("X", 32'(X), 32'(m_x));
      check_val("key_valid", 32'(key_valid), 32'(m_valid));
      check_val("key_held", 32'(key_held), 32'(m_held));
      check_val("multi_key", 32'(multi_key), 32'(m_multi));
      check_val("valid_multi_excl", 32'(key_valid & multi_key), 32'd0);
      if (key_valid) begin
        valid_seen++;
        if (lat_valid < 0) lat_valid = i + 1;
      end
      if (multi_key) multi_seen++;
      if (!key_held && lat_fall < 0) lat_fall = i + 1;
    end
  endtask

  initial begin
    int v0;
    int m0;
    int kind;
    int len;
    logic [9:0] one;
    logic [9:0] pat;

    model_reset();
    one = 10'b0000000001;

    // 1: reset with every key down
    rst_n    = 1'b0;
    keys_raw = 10'b1111111111;
    step(3);
    check_val("t1_rst_x", 32'(X), 32'h001);
    check_val("t1_rst_outs", 32'({key_valid, key_held, multi_key}), 32'd0);
    rst_n    = 1'b1;
    keys_raw = 10'b0000000000;
    v0 = valid_seen; m0 = multi_seen;
    step(6);
    check_val("t1_quiet", 32'((valid_seen - v0) + (multi_seen - m0)), 32'd0);

    // 2: clean press and release of digit 5
    keys_raw = 10'b0000100000;
    v0 = valid_seen;
    step(30);
    check_val("t2_latency", 32'(lat_valid), 32'd10);
    check_val("t2_count", 32'(valid_seen - v0), 32'd1);
    keys_raw = 10'b0000000000;
    step(15);
    check_val("t2_release_lat", 32'(lat_fall), 32'd10);
    check_val("t2_x_hold", 32'(X), 32'h020);

    // 3: bouncing digit 3, then steady
    v0 = valid_seen;
    for (int p = 0; p < 5; p++) begin
      keys_raw = 10'b0000001000;
      step(3);
      keys_raw = 10'b0000000000;
      step(3);
    end
    keys_raw = 10'b0000001000;
    step(20);
    check_val("t3_latency", 32'(lat_valid), 32'd10);
    check_val("t3_count", 32'(valid_seen - v0), 32'd1);
    check_val("t3_x", 32'(X), 32'h008);
    keys_raw = 10'b0000000000;
    step(15);

    // 4: two keys from idle, then one
    v0 = valid_seen; m0 = multi_seen;
    keys_raw = 10'b0000000011;
    step(20);
    check_val("t4_multi_seen", 32'(multi_seen > m0), 32'd1);
    check_val("t4_no_valid", 32'(valid_seen - v0), 32'd0);
    check_val("t4_x_kept", 32'(X), 32'h008);
    keys_raw = 10'b0000000010;
    step(12);
    check_val("t4_latency", 32'(lat_valid), 32'd10);
    check_val("t4_x", 32'(X), 32'h002);
    keys_raw = 10'b0000000000;
    step(15);

    // 5: roll-over blocked, then fresh press of digit 7
    keys_raw = 10'b0000000100;
    step(12);
    v0 = valid_seen;
    keys_raw = 10'b0010000100;
    step(5);
    keys_raw = 10'b0010000000;
    step(5);
    keys_raw = 10'b0000000000;
    step(15);
    check_val("t5_rollover", 32'(valid_seen - v0), 32'd0);
    keys_raw = 10'b0010000000;
    step(12);
    check_val("t5_x7", 32'(X), 32'h080);
    keys_raw = 10'b0000000000;
    step(15);

    // 5b: reset in the middle of debouncing digit 9
    keys_raw = 10'b1000000000;
    step(6);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    v0 = valid_seen;
    step(9);
    check_val("t5_rst_no_valid", 32'(valid_seen - v0), 32'd0);
    check_val("t5_rst_x", 32'(X), 32'h001);
    step(1);
    check_val("t5_redebounce", 32'(key_valid), 32'd1);
    keys_raw = 10'b0000000000;
    step(15);

    // 6: long hold of digit 9
    keys_raw = 10'b1000000000;
    v0 = valid_seen;
    step(70);
`ifdef AUTO_REPEAT_EN
    check_val("t6_pulses", 32'(valid_seen - v0), 32'd4);
`else
    check_val("t6_pulses", 32'(valid_seen - v0), 32'd1);
`endif
    check_val("t6_x", 32'(X), 32'h200);
    keys_raw = 10'b0000000000;
    step(15);

    // Randomized episodes of idle, single, and multi key patterns
    for (int e = 0; e < 300; e++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 20);
      if (kind == 0) begin
        pat = 10'b0000000000;
      end else if (kind == 3) begin
        pat = 10'($urandom);
        if ($countones(pat) < 2) pat = pat | 10'b0000000011;
      end else begin
        pat = one << $urandom_range(0, 9);
      end
      keys_raw = pat;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(len);
    end
    keys_raw = 10'b0000000000;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
